// File: rtl/ring_shifter_pkg.sv
// Shared constants and helpers for the 4-stage XOR-injection ring shifter.
package ring_shifter_pkg;

  localparam int unsigned RS_WIDTH = 4;
  localparam int unsigned RS_OCC_W = $clog2(RS_WIDTH + 1);
  localparam logic [RS_WIDTH-1:0] RS_RESET_VAL = {RS_WIDTH{1'b0}};

  // Number of set bits in a ring image.
  function automatic logic [RS_OCC_W-1:0] rs_popcount(input logic [RS_WIDTH-1:0] v);
    logic [RS_OCC_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < RS_WIDTH; i++) begin
      cnt = cnt + RS_OCC_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ring_shifter_4bit.sv
// Rotate-left ring register whose recirculated bit is XORed with serial input d.
// Define RING_SHIFTER_OCC_EN to add the registered population-count port occ.
module ring_shifter_4bit
  import ring_shifter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                d,
`ifdef RING_SHIFTER_OCC_EN
  output logic [RS_OCC_W-1:0] occ,
`endif
  output logic [RS_WIDTH-1:0] q
);

  logic [RS_WIDTH-1:0] q_d;
  logic [RS_WIDTH-1:0] q_q;
`ifdef RING_SHIFTER_OCC_EN
  logic [RS_OCC_W-1:0] occ_d;
  logic [RS_OCC_W-1:0] occ_q;
`endif

  // Next ring image: exit stage wraps to entry stage, toggled by d.
  always_comb begin
    q_d = {q_q[RS_WIDTH-2:0], q_q[RS_WIDTH-1] ^ d};
`ifdef RING_SHIFTER_OCC_EN
    occ_d = rs_popcount(q_d);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RS_RESET_VAL;
`ifdef RING_SHIFTER_OCC_EN
      occ_q <= rs_popcount(RS_RESET_VAL);
`endif
    end else begin
      q_q <= q_d;
`ifdef RING_SHIFTER_OCC_EN
      occ_q <= occ_d;
`endif
    end
  end

  assign q = q_q;
`ifdef RING_SHIFTER_OCC_EN
  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_ring_shifter_4bit.sv
// Self-checking bench for ring_shifter_4bit: directed vector table plus randomized run.
module tb_ring_shifter_4bit;

  logic       clk;
  logic       rst;
  logic       d;
  logic [3:0] q;
`ifdef RING_SHIFTER_OCC_EN
  logic [2:0] occ;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ring_shifter_4bit dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
`ifdef RING_SHIFTER_OCC_EN
    .occ (occ),
`endif
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       d;
    logic [3:0] exp_q;
    int         exp_occ;
    string      name;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and compare outputs just after the edge.
  task automatic step(input logic r, input logic dv, input logic [3:0] eq,
                      input int eocc, input string name);
    @(negedge clk);
    rst = r;
    d   = dv;
    @(posedge clk);
    #1;
    check({name, ".q"}, int'(q), int'(eq));
`ifdef RING_SHIFTER_OCC_EN
    check({name, ".occ"}, int'(occ), eocc);
`endif
  endtask

  vec_t vecs[$];
  logic [3:0] model;

  initial begin
    rst = 1'b1;
    d   = 1'b1;

    // Reset wins over d, then single injected 1 walks and wraps.
    vecs.push_back('{1'b1, 1'b1, 4'b0000, 0, "rst_wins"});
    vecs.push_back('{1'b0, 1'b1, 4'b0001, 1, "inj1"});
    vecs.push_back('{1'b0, 1'b0, 4'b0010, 1, "walk1"});
    vecs.push_back('{1'b0, 1'b0, 4'b0100, 1, "walk2"});
    vecs.push_back('{1'b0, 1'b0, 4'b1000, 1, "walk3"});
    vecs.push_back('{1'b0, 1'b0, 4'b0001, 1, "wrap"});
    vecs.push_back('{1'b0, 1'b0, 4'b0010, 1, "walk4"});
    vecs.push_back('{1'b0, 1'b0, 4'b0100, 1, "walk5"});
    vecs.push_back('{1'b0, 1'b0, 4'b1000, 1, "walk6"});
    // Exit bit cancelled by d=1, empty ring stays empty.
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 0, "cancel"});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 0, "empty_hold"});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 0, "empty_hold2"});
    // Fill, all-ones hold, then all-ones with d=1.
    vecs.push_back('{1'b0, 1'b1, 4'b0001, 1, "fill1"});
    vecs.push_back('{1'b0, 1'b1, 4'b0011, 2, "fill2"});
    vecs.push_back('{1'b0, 1'b1, 4'b0111, 3, "fill3"});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 4, "fill4"});
    vecs.push_back('{1'b0, 1'b0, 4'b1111, 4, "ones_hold"});
    vecs.push_back('{1'b0, 1'b1, 4'b1110, 3, "ones_d1"});
    vecs.push_back('{1'b0, 1'b0, 4'b1101, 3, "rot_1110"});
    // Build 0110, then reset mid-operation and resume.
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 0, "rst_again"});
    vecs.push_back('{1'b0, 1'b1, 4'b0001, 1, "b1"});
    vecs.push_back('{1'b0, 1'b1, 4'b0011, 2, "b2"});
    vecs.push_back('{1'b0, 1'b0, 4'b0110, 2, "b3_0110"});
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 0, "rst_mid"});
    vecs.push_back('{1'b0, 1'b1, 4'b0001, 1, "resume"});

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].d, vecs[i].exp_q, vecs[i].exp_occ, vecs[i].name);

    // Random run against an arithmetic model: rotate-left by one, then XOR d into bit 0.
    model = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      logic r;
      logic dv;
      r  = ($urandom_range(0, 19) == 0);
      dv = 1'($urandom_range(0, 1));
      if (r)
        model = 4'b0000;
      else
        model = 4'((((int'(model) * 2) + (int'(model) / 8)) % 16) ^ int'(dv));
      step(r, dv, model, $countones(model), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
